// File: rtl/deser_arb_pkg.sv
// Shared types and helpers for the deserializer arbiter.
package deser_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2
    } state_e;

    // Channel-index width, never narrower than one bit.
    function automatic int unsigned chan_w(input int unsigned n);
        return (n <= 1) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/deserializer_arbiter_rr_picker.sv
// Combinational winner selection among requesting channels.
// DESER_ARB_FIXED_PRIO_EN selects lowest-index-wins instead of round-robin.
module rr_picker
    import deser_arb_pkg::*;
#(
    parameter  int unsigned N_CHANNELS = 4,
    localparam int unsigned CHAN_W     = chan_w(N_CHANNELS)
) (
    input  logic [N_CHANNELS-1:0] req,
    input  logic [CHAN_W-1:0]     last_grant,
    output logic [CHAN_W-1:0]     winner,
    output logic                  any_val
);

`ifdef DESER_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    always_comb begin
        winner  = '0;
        any_val = |req;
        for (int i = N_CHANNELS - 1; i >= 0; i--) begin
            if (req[i]) winner = CHAN_W'(i);
        end
    end
`else
    logic [2*N_CHANNELS-1:0] rot;
    int unsigned             off;

    // Rotate so bit 0 is the channel just after last_grant, then take the lowest set bit.
    always_comb begin
        winner  = '0;
        any_val = |req;
        off     = 0;
        rot     = {req, req} >> (int'(last_grant) + 1);
        for (int j = N_CHANNELS - 1; j >= 0; j--) begin
            if (rot[j]) off = 32'(j);
        end
        winner = CHAN_W'((int'(last_grant) + 1 + int'(off)) % int'(N_CHANNELS));
    end
`endif

endmodule

// File: rtl/deserializer_arbiter.sv
// Grants one channel per frame onto a shared deserializer and tags the frame with its source.
// Build option: DESER_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
module deserializer_arbiter
    import deser_arb_pkg::*;
#(
    parameter  int unsigned BIT_WIDTH  = 32,
    parameter  int unsigned N_SAMPLES  = 8,
    parameter  int unsigned N_CHANNELS = 4,
    localparam int unsigned CHAN_W     = chan_w(N_CHANNELS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_CHANNELS*BIT_WIDTH-1:0] req_msg,
    input  logic [N_CHANNELS-1:0]           req_val,
    output logic [N_CHANNELS-1:0]           req_rdy,
    output logic [BIT_WIDTH-1:0]            deser_msg,
    output logic                            deser_val,
    input  logic                            deser_rdy,
    input  logic                            frame_val,
    input  logic                            frame_rdy,
    output logic [CHAN_W-1:0]               frame_chan,
    output logic                            busy
);

    localparam int unsigned CNT_W = $clog2(N_SAMPLES + 1);

    state_e              state_q, state_d;
    logic [CHAN_W-1:0]   grant_q, grant_d;
    logic [CHAN_W-1:0]   last_q,  last_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;

    logic [CHAN_W-1:0]   pick_c;
    logic                any_c;
    logic [BIT_WIDTH-1:0] sel_msg_c;
    logic                sel_val_c;
    logic                beat_c;

    rr_picker #(.N_CHANNELS(N_CHANNELS)) u_picker (
        .req        (req_val),
        .last_grant (last_q),
        .winner     (pick_c),
        .any_val    (any_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= CHAN_W'(N_CHANNELS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Granted channel's stream, selected without index arithmetic on the bus.
    always_comb begin
        sel_msg_c = '0;
        sel_val_c = 1'b0;
        for (int c = 0; c < N_CHANNELS; c++) begin
            if (grant_q == CHAN_W'(c)) begin
                sel_msg_c = req_msg[c*BIT_WIDTH +: BIT_WIDTH];
                sel_val_c = req_val[c];
            end
        end
    end

    always_comb begin
        req_rdy   = '0;
        deser_msg = '0;
        deser_val = 1'b0;
        if (state_q == STREAM) begin
            deser_msg = sel_msg_c;
            deser_val = sel_val_c;
            for (int c = 0; c < N_CHANNELS; c++) begin
                req_rdy[c] = (grant_q == CHAN_W'(c)) && deser_rdy;
            end
        end
    end

    assign beat_c     = deser_val && deser_rdy;
    assign frame_chan = grant_q;
    assign busy       = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_c) begin
                    state_d = STREAM;
                    grant_d = pick_c;
                    last_d  = pick_c;
                    cnt_d   = '0;
                end
            end
            STREAM: begin
                if (beat_c) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N_SAMPLES - 1)) state_d = WAIT;
                end
            end
            WAIT: begin
                // Grant is held until the assembled frame leaves the deserializer.
                if (frame_val && frame_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
